// File: rtl/rf_wport_arbiter_pkg.sv
// Shared widths, constants and types for the register-file write-port arbiter.
package rf_wport_arbiter_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned WB_W  = REG_W + XLEN;

  localparam logic [REG_W-1:0] X0 = '0;

  // One buffered long-unit result: destination register and data.
  typedef struct packed {
    logic [REG_W-1:0] wr;
    logic [XLEN-1:0]  wd;
  } wb_entry_t;

  // Which source owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PIPE,
    SRC_FIFO
  } wsrc_e;

endpackage

// File: rtl/rf_wb_fifo.sv
// Generic synchronous FIFO; pointers carry one extra wrap bit so full and
// empty are distinguishable without an occupancy counter.
module rf_wb_fifo
  import rf_wport_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = WB_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wptr, rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr[AW-1:0]];

  // Pointer advance; reset discards all contents at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
    end
  end

  // Entry storage; contents are meaningless while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Arbitrates the register file's single write port between the in-order
// pipeline writeback and buffered long-latency results, with a busy-register
// scoreboard for decode hazards and an anti-starvation forced drain.
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned STARVE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p_we,
  input  logic [REG_W-1:0] p_wr,
  input  logic [XLEN-1:0]  p_wd,
  input  logic             iss_valid,
  input  logic [REG_W-1:0] iss_wr,
  output logic             iss_ready,
  input  logic             l_valid,
  input  logic [REG_W-1:0] l_wr,
  input  logic [XLEN-1:0]  l_wd,
  output logic             l_ready,
  input  logic [REG_W-1:0] chk_r1,
  input  logic [REG_W-1:0] chk_r2,
  output logic             hazard,
  output logic             stall_pipe,
  output logic             rf_we,
  output logic [REG_W-1:0] rf_wr,
  output logic [XLEN-1:0]  rf_wd,
  output logic             err_waw
);

  localparam int unsigned     CW        = $clog2(STARVE + 1);
  localparam logic [CW-1:0]   STARVE_C  = CW'(STARVE);
  localparam logic [CW-1:0]   CNT_ONE   = 1;

  wb_entry_t     head_e;
  wb_entry_t     push_e;
  logic          fifo_full, fifo_empty;
  logic          fifo_push, fifo_pop;
  wsrc_e         src;
  logic [31:1]   busy_q;
  logic [31:0]   busy;
  logic [CW-1:0] starve_cnt;
  logic          iss_fire;

  assign push_e    = '{wr: l_wr, wd: l_wd};
  assign l_ready   = !fifo_full;
  assign fifo_push = l_valid && l_ready;
  assign fifo_pop  = (src == SRC_FIFO);

  rf_wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WB_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (push_e),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head_e)
  );

  assign stall_pipe = (starve_cnt == STARVE_C) && !fifo_empty;

  // Write-port source selection: forced drain, then pipeline, then FIFO.
  always_comb begin
    src = SRC_NONE;
    if (stall_pipe)      src = SRC_FIFO;
    else if (p_we)       src = SRC_PIPE;
    else if (!fifo_empty) src = SRC_FIFO;
  end

  // Register-file write outputs driven from the selected source, zero when idle.
  always_comb begin
    rf_we = 1'b0;
    rf_wr = '0;
    rf_wd = '0;
    case (src)
      SRC_PIPE: begin
        rf_we = 1'b1;
        rf_wr = p_wr;
        rf_wd = p_wd;
      end
      SRC_FIFO: begin
        rf_we = 1'b1;
        rf_wr = head_e.wr;
        rf_wd = head_e.wd;
      end
      default: ;
    endcase
  end

  // x0 is never tracked, so it can never report busy.
  assign busy      = {busy_q, 1'b0};
  assign iss_ready = !busy[iss_wr];
  assign iss_fire  = iss_valid && iss_ready && (iss_wr != X0);
  assign hazard    = busy[chk_r1] | busy[chk_r2];

  // Scoreboard: set on accepted issue, clear when that result commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      for (int unsigned i = 1; i < 32; i++) begin
        if (iss_fire && (iss_wr == REG_W'(i)))
          busy_q[i] <= 1'b1;
        else if (fifo_pop && (head_e.wr == REG_W'(i)))
          busy_q[i] <= 1'b0;
      end
    end
  end

  // Sticky WAW error when the pipeline commits to a register still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_waw <= 1'b0;
    else if ((src == SRC_PIPE) && busy[p_wr] && (p_wr != X0))
      err_waw <= 1'b1;
  end

  // Starvation counter: counts pipeline wins over a waiting FIFO, cleared by any dequeue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      starve_cnt <= '0;
    else if (fifo_pop)
      starve_cnt <= '0;
    else if (!fifo_empty && (src == SRC_PIPE) && (starve_cnt != STARVE_C))
      starve_cnt <= starve_cnt + CNT_ONE;
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter with a reference model and a queue of
// expected long-result commits.
module tb_rf_wport_arbiter;
  import rf_wport_arbiter_pkg::*;

  localparam int unsigned DEPTH  = 2;
  localparam int unsigned STARVE = 4;

  logic        clk, rst;
  logic        p_we;
  logic [4:0]  p_wr;
  logic [31:0] p_wd;
  logic        iss_valid;
  logic [4:0]  iss_wr;
  logic        iss_ready;
  logic        l_valid;
  logic [4:0]  l_wr;
  logic [31:0] l_wd;
  logic        l_ready;
  logic [4:0]  chk_r1, chk_r2;
  logic        hazard, stall_pipe, rf_we, err_waw;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wd;

  rf_wport_arbiter #(
    .DEPTH  (DEPTH),
    .STARVE (STARVE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .p_we       (p_we),
    .p_wr       (p_wr),
    .p_wd       (p_wd),
    .iss_valid  (iss_valid),
    .iss_wr     (iss_wr),
    .iss_ready  (iss_ready),
    .l_valid    (l_valid),
    .l_wr       (l_wr),
    .l_wd       (l_wd),
    .l_ready    (l_ready),
    .chk_r1     (chk_r1),
    .chk_r2     (chk_r2),
    .hazard     (hazard),
    .stall_pipe (stall_pipe),
    .rf_we      (rf_we),
    .rf_wr      (rf_wr),
    .rf_wd      (rf_wd),
    .err_waw    (err_waw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  wb_entry_t   exp_q[$];
  logic [31:0] m_busy;
  int unsigned m_starve;
  logic        m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_busy   = '0;
    m_starve = 0;
    m_err    = 1'b0;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic step(input string tag);
    wsrc_e       src;
    wb_entry_t   e;
    logic        m_full, m_empty, m_stall, iss_acc, l_acc;
    logic        exp_we;
    logic [4:0]  exp_wr;
    logic [31:0] exp_wd;
    @(negedge clk);
    m_empty = (exp_q.size() == 0);
    m_full  = (exp_q.size() == DEPTH);
    m_stall = (m_starve == STARVE) && !m_empty;
    e = '0;
    if (!m_empty) e = exp_q[0];
    if (m_stall)      src = SRC_FIFO;
    else if (p_we)    src = SRC_PIPE;
    else if (!m_empty) src = SRC_FIFO;
    else              src = SRC_NONE;
    exp_we = (src != SRC_NONE);
    exp_wr = (src == SRC_PIPE) ? p_wr : (src == SRC_FIFO) ? e.wr : 5'd0;
    exp_wd = (src == SRC_PIPE) ? p_wd : (src == SRC_FIFO) ? e.wd : 32'd0;
    chk({tag, ".rf_we"},      32'(rf_we),      32'(exp_we));
    chk({tag, ".rf_wr"},      32'(rf_wr),      32'(exp_wr));
    chk({tag, ".rf_wd"},      rf_wd,           exp_wd);
    chk({tag, ".stall_pipe"}, 32'(stall_pipe), 32'(m_stall));
    chk({tag, ".l_ready"},    32'(l_ready),    32'(!m_full));
    chk({tag, ".iss_ready"},  32'(iss_ready),  32'(!m_busy[iss_wr]));
    chk({tag, ".hazard"},     32'(hazard),     32'(m_busy[chk_r1] | m_busy[chk_r2]));
    chk({tag, ".err_waw"},    32'(err_waw),    32'(m_err));
    iss_acc = iss_valid && !m_busy[iss_wr] && (iss_wr != 5'd0);
    l_acc   = l_valid && !m_full;
    @(posedge clk);
    if ((src == SRC_PIPE) && (p_wr != 5'd0) && m_busy[p_wr]) m_err = 1'b1;
    if (src == SRC_FIFO) begin
      if (e.wr != 5'd0) m_busy[e.wr] = 1'b0;
      void'(exp_q.pop_front());
      m_starve = 0;
    end else if ((src == SRC_PIPE) && !m_empty) begin
      m_starve++;
    end
    if (iss_acc) m_busy[iss_wr] = 1'b1;
    if (l_acc) exp_q.push_back('{wr: l_wr, wd: l_wd});
    #1;
  endtask

  initial begin
    rst = 1'b1;
    p_we = 0; p_wr = '0; p_wd = '0;
    iss_valid = 0; iss_wr = '0;
    l_valid = 0; l_wr = '0; l_wd = '0;
    chk_r1 = '0; chk_r2 = '0;
    model_reset();

    // Reset state
    #12;
    chk("rst.rf_we",      32'(rf_we),      32'd0);
    chk("rst.l_ready",    32'(l_ready),    32'd1);
    chk("rst.iss_ready",  32'(iss_ready),  32'd1);
    chk("rst.hazard",     32'(hazard),     32'd0);
    chk("rst.stall_pipe", 32'(stall_pipe), 32'd0);
    chk("rst.err_waw",    32'(err_waw),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    step("idle0");
    step("idle1");

    // Issue x5, observe hazard, return result, commit, hazard clears
    iss_valid = 1; iss_wr = 5'd5;
    step("iss5");
    iss_valid = 0; chk_r1 = 5'd5;
    step("busy5");
    l_valid = 1; l_wr = 5'd5; l_wd = 32'hDEADBEEF;
    step("l5_push");
    l_valid = 0;
    step("l5_commit");
    step("l5_clear");
    chk_r1 = '0;

    // Starvation: pipeline writes x3 every cycle while x7 waits
    p_we = 1; p_wr = 5'd3; p_wd = 32'h3000_0000;
    l_valid = 1; l_wr = 5'd7; l_wd = 32'h0000_0777;
    step("starve_push");
    l_valid = 0;
    for (int i = 0; i < 6; i++) begin
      p_wd = 32'h3000_0001 + 32'(i);
      step("starve");
    end

    // Fill to full under constant pipeline pressure, drain across pointer wraps
    for (int r = 0; r < 3; r++) begin
      p_we = (r != 2);
      for (int k = 0; k < 3; k++) begin
        l_valid = 1;
        l_wr = 5'($urandom_range(31, 1));
        l_wd = $urandom;
        p_wd = $urandom;
        step("fill");
      end
      l_valid = 0;
      for (int k = 0; k < 12; k++) begin
        p_wd = $urandom;
        step("drain");
      end
    end
    p_we = 0;

    // x0 issue and result
    iss_valid = 1; iss_wr = 5'd0;
    step("iss0");
    iss_valid = 0;
    l_valid = 1; l_wr = 5'd0; l_wd = 32'h0000_0BAD;
    step("l0_push");
    l_valid = 0;
    step("l0_commit");
    step("l0_after");

    // WAW error, stickiness, and async reset with a non-empty FIFO
    iss_valid = 1; iss_wr = 5'd9;
    step("iss9");
    iss_valid = 0; chk_r1 = 5'd9;
    p_we = 1; p_wr = 5'd9; p_wd = 32'h0000_0099;
    step("waw");
    p_we = 0;
    step("waw_sticky0");
    step("waw_sticky1");
    p_we = 1; p_wr = 5'd3; p_wd = 32'h0000_0033;
    l_valid = 1; l_wr = 5'd9; l_wd = 32'h0000_1234;
    step("l9_push");
    l_valid = 0; p_we = 0;
    #1;
    chk("pre_rst.rf_we", 32'(rf_we), 32'd1);
    chk("pre_rst.rf_wd", rf_wd,      32'h0000_1234);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst.rf_we",   32'(rf_we),   32'd0);
    chk("async_rst.l_ready", 32'(l_ready), 32'd1);
    chk("async_rst.hazard",  32'(hazard),  32'd0);
    chk("async_rst.err_waw", 32'(err_waw), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    step("post_rst0");
    step("post_rst1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
